// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants for the memory arbiter.
//   - FSM state encodings (2-bit, legacy-compatible values)
//   - default memory read latency
package mem_arbiter_pkg;

    localparam int LAT_DEFAULT = 1;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_ISSUE = 2'd1;
    localparam arb_state_t ST_WAIT  = 2'd2;
    localparam arb_state_t ST_ACK   = 2'd3;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side bus of the memory arbiter.
//   req/rw/addr/wdata : per-requester request bundle (port i at [i*W +: W])
//   ack/rdata         : one-cycle completion pulse and read data
//   mem_*             : single-port synchronous memory handshake
// Modports:
//   master : requesters + memory model (drive req side, return mem_rdata)
//   slave  : the arbiter
interface mem_arbiter_if #(
    parameter int N  = 3,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [N-1:0]    req;
    logic [N-1:0]    rw;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic            mem_en;
    logic            mem_rw;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    modport master (
        output req, rw, addr, wdata, mem_rdata,
        input  ack, rdata, mem_en, mem_rw, mem_addr, mem_wdata
    );

    modport slave (
        input  req, rw, addr, wdata, mem_rdata,
        output ack, rdata, mem_en, mem_rw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req    in  N  : pending requests
//   last   in  PW : previous winner; search starts at last+1 (mod N)
//   any    out 1  : at least one request pending
//   winner out PW : selected port (0 when none)
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] last,
    output logic          any,
    output logic [PW-1:0] winner
);
    always_comb begin
        int unsigned idx;
        any    = 1'b0;
        winner = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            // wrap by subtraction: last+k never exceeds 2N-1
            idx = 32'(last) + k;
            if (idx >= 32'(N))
                idx = idx - 32'(N);
            if (!any && req[idx[PW-1:0]]) begin
                any    = 1'b1;
                winner = idx[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port synchronous
// memory among N requesters, one access at a time (IDLE/ISSUE/WAIT/ACK).
//   clk   in  : clock, rising edge
//   reset in  : synchronous, active-high
//   bus       : mem_arbiter_if.slave (requester req/ack + memory strobe)
//   busy  out : high whenever the FSM is not in IDLE
// A request seen in IDLE cycle c strobes memory in c+1, samples mem_rdata
// in c+1+LAT, acks in c+2+LAT and is back in IDLE in c+3+LAT.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N   = 3,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = LAT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic         busy
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(LAT + 1);

    arb_state_t    state;
    logic [PW-1:0] last;
    logic [PW-1:0] gnt;
    logic          cap_rw;
    logic [CW-1:0] cnt;
    logic          pick_any;
    logic [PW-1:0] pick_win;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req    (bus.req),
        .last   (last),
        .any    (pick_any),
        .winner (pick_win)
    );

    always_comb busy = (state != ST_IDLE);

    // The mem_* output registers double as the address/wdata capture
    // registers: they are loaded at grant and are only visible in ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            last          <= PW'(N - 1);
            gnt           <= '0;
            cap_rw        <= 1'b0;
            cnt           <= '0;
            bus.ack       <= '0;
            bus.rdata     <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_rw    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt           <= pick_win;
                        last          <= pick_win;
                        cap_rw        <= bus.rw[pick_win];
                        bus.mem_en    <= 1'b1;
                        bus.mem_rw    <= bus.rw[pick_win];
                        bus.mem_addr  <= bus.addr[pick_win*AW +: AW];
                        bus.mem_wdata <= bus.wdata[pick_win*DW +: DW];
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    bus.mem_en    <= 1'b0;
                    bus.mem_rw    <= 1'b0;
                    bus.mem_addr  <= '0;
                    bus.mem_wdata <= '0;
                    cnt           <= CW'(LAT);
                    state         <= ST_WAIT;
                end
                ST_WAIT: begin
                    // cnt==1 marks the cycle mem_rdata is valid
                    if (cnt == CW'(1)) begin
                        bus.rdata <= cap_rw ? '0 : bus.mem_rdata;
                        bus.ack   <= N'(1) << gnt;
                        state     <= ST_ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    bus.ack   <= '0;
                    bus.rdata <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter at LAT=1 (dut_a) and
// LAT=3 (dut_b). Expected memory strobes and acks, each tagged with the
// cycle they must appear in, are queued when requests are driven and
// popped by per-DUT monitors sampling on the falling edge.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    localparam logic [31:0] NOVALID = 32'hBAD0_BAD0;

    mem_arbiter_if #(.N(3), .AW(32), .DW(32)) bus_a ();
    mem_arbiter_if #(.N(3), .AW(32), .DW(32)) bus_b ();
    logic busy_a, busy_b;

    mem_arbiter #(.N(3), .AW(32), .DW(32), .LAT(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .busy(busy_a)
    );
    mem_arbiter #(.N(3), .AW(32), .DW(32), .LAT(3)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .busy(busy_b)
    );

    // memory contents: 0x100 holds DEADBEEF, otherwise derived from address
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    // read data is valid only in the cycle exactly LAT after the strobe
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];
    always @(posedge clk) begin
        pipe_a    <= (bus_a.mem_en && !bus_a.mem_rw) ? mem_fn(bus_a.mem_addr) : NOVALID;
        pipe_b[0] <= (bus_b.mem_en && !bus_b.mem_rw) ? mem_fn(bus_b.mem_addr) : NOVALID;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign bus_a.mem_rdata = pipe_a;
    assign bus_b.mem_rdata = pipe_b[2];

    typedef struct {
        int unsigned cyc;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        int unsigned cyc;
        int unsigned port;
        logic [31:0] data;
    } ack_exp_t;

    mem_exp_t mq_a[$], mq_b[$];
    ack_exp_t aq_a[$], aq_b[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // grant in IDLE cycle g: strobe in g+1, ack in g+2+LAT
    task automatic expect_access(input bit on_b, input int unsigned g, input int unsigned port,
                                 input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                                 input bit with_ack);
        mem_exp_t m;
        ack_exp_t a;
        int unsigned lat;
        lat = on_b ? 3 : 1;
        m = '{cyc: g + 1, rw: rw, addr: addr, wdata: wdata};
        a = '{cyc: g + 2 + lat, port: port, data: rw ? 32'h0 : mem_fn(addr)};
        if (on_b) begin
            mq_b.push_back(m);
            if (with_ack) aq_b.push_back(a);
        end else begin
            mq_a.push_back(m);
            if (with_ack) aq_a.push_back(a);
        end
    endtask

    task automatic set_port(input bit on_b, input int unsigned p, input logic r, input logic rw,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (on_b) begin
            bus_b.req[p] = r;
            bus_b.rw[p]  = rw;
            bus_b.addr[p*32 +: 32]  = addr;
            bus_b.wdata[p*32 +: 32] = wdata;
        end else begin
            bus_a.req[p] = r;
            bus_a.rw[p]  = rw;
            bus_a.addr[p*32 +: 32]  = addr;
            bus_a.wdata[p*32 +: 32] = wdata;
        end
    endtask

    task automatic monitor(input bit on_b, input logic [2:0] ack, input logic [31:0] rdata,
                           input logic mem_en, input logic mem_rw,
                           input logic [31:0] mem_addr, input logic [31:0] mem_wdata);
        string pre;
        mem_exp_t m;
        ack_exp_t a;
        int unsigned sz;
        pre = on_b ? "b." : "a.";
        check_val({pre, "ack_onehot0"}, 64'($onehot0(ack)), 64'd1);
        if (mem_en) begin
            sz = on_b ? mq_b.size() : mq_a.size();
            if (sz == 0) begin
                check_val({pre, "mem_unexpected"}, 64'(sz), 64'd1);
            end else begin
                if (on_b) m = mq_b.pop_front();
                else      m = mq_a.pop_front();
                check_val({pre, "mem_cyc"},   64'(cyc), 64'(m.cyc));
                check_val({pre, "mem_rw"},    64'(mem_rw), 64'(m.rw));
                check_val({pre, "mem_addr"},  64'(mem_addr), 64'(m.addr));
                check_val({pre, "mem_wdata"}, 64'(mem_wdata), 64'(m.wdata));
            end
        end else begin
            check_val({pre, "mem_quiet"}, {mem_addr, mem_wdata} | 64'(mem_rw), 64'd0);
        end
        if (ack != 3'b000) begin
            sz = on_b ? aq_b.size() : aq_a.size();
            if (sz == 0) begin
                check_val({pre, "ack_unexpected"}, 64'(sz), 64'd1);
            end else begin
                if (on_b) a = aq_b.pop_front();
                else      a = aq_a.pop_front();
                check_val({pre, "ack_cyc"},   64'(cyc), 64'(a.cyc));
                check_val({pre, "ack_port"},  64'(ack), 64'(3'b001 << a.port));
                check_val({pre, "ack_rdata"}, 64'(rdata), 64'(a.data));
            end
        end else begin
            check_val({pre, "rdata_idle"}, 64'(rdata), 64'd0);
        end
    endtask

    always @(negedge clk)
        if (cyc >= 1)
            monitor(1'b0, bus_a.ack, bus_a.rdata, bus_a.mem_en, bus_a.mem_rw,
                    bus_a.mem_addr, bus_a.mem_wdata);

    always @(negedge clk)
        if (cyc >= 1)
            monitor(1'b1, bus_b.ack, bus_b.rdata, bus_b.mem_en, bus_b.mem_rw,
                    bus_b.mem_addr, bus_b.mem_wdata);

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        int unsigned g;
        int unsigned h;
        logic [31:0] fa [3];
        fa[0] = 32'h10; fa[1] = 32'h20; fa[2] = 32'h30;

        reset = 1'b1;
        bus_a.req = '0; bus_a.rw = '0; bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req = '0; bus_b.rw = '0; bus_b.addr = '0; bus_b.wdata = '0;
        repeat (2) @(negedge clk);

        // reset state, and reset wins over a simultaneous request
        check_val("rst_busy", 64'(busy_a), 64'd0);
        check_val("rst_mem_en", 64'(bus_a.mem_en), 64'd0);
        set_port(1'b0, 1, 1'b1, 1'b0, 32'h100, 32'h0);
        repeat (2) @(negedge clk);
        check_val("rst_req_busy", 64'(busy_a), 64'd0);
        check_val("rst_req_ack", 64'(bus_a.ack), 64'd0);
        set_port(1'b0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // single read, port 1
        set_port(1'b0, 1, 1'b1, 1'b0, 32'h100, 32'h0);
        g = cyc;
        expect_access(1'b0, g, 1, 1'b0, 32'h100, 32'h0, 1'b1);
        @(negedge clk);
        check_val("rd_busy_c1", 64'(busy_a), 64'd1);
        wait_until(g + 3);
        set_port(1'b0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_val("rd_busy_c4", 64'(busy_a), 64'd0);

        // fairness from reset: all three held
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int unsigned p = 0; p < 3; p++) set_port(1'b0, p, 1'b1, 1'b0, fa[p], 32'h0);
        g = cyc;
        for (int unsigned k = 0; k < 6; k++)
            expect_access(1'b0, g + 4*k, k % 3, 1'b0, fa[k % 3], 32'h0, 1'b1);
        wait_until(g + 23);
        bus_a.req = '0;
        @(negedge clk);
        check_val("fair_idle", 64'(busy_a), 64'd0);

        // write, port 2
        set_port(1'b0, 2, 1'b1, 1'b1, 32'h1000, 32'h1234_5678);
        g = cyc;
        expect_access(1'b0, g, 2, 1'b1, 32'h1000, 32'h1234_5678, 1'b1);
        wait_until(g + 3);
        set_port(1'b0, 2, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // skip idle port 1: ports 0 and 2 held (last = 2, so 0 first)
        set_port(1'b0, 0, 1'b1, 1'b0, 32'h40, 32'h0);
        set_port(1'b0, 2, 1'b1, 1'b1, 32'h2000, 32'hCAFE_F00D);
        g = cyc;
        for (int unsigned k = 0; k < 4; k++) begin
            if (k % 2 == 0) expect_access(1'b0, g + 4*k, 0, 1'b0, 32'h40, 32'h0, 1'b1);
            else            expect_access(1'b0, g + 4*k, 2, 1'b1, 32'h2000, 32'hCAFE_F00D, 1'b1);
        end
        wait_until(g + 15);
        bus_a.req = '0;
        @(negedge clk);

        // reset in the WAIT cycle of a port-1 read: no ack ever
        set_port(1'b0, 1, 1'b1, 1'b0, 32'h300, 32'h0);
        g = cyc;
        expect_access(1'b0, g, 1, 1'b0, 32'h300, 32'h0, 1'b0);
        wait_until(g + 2);
        reset = 1'b1;
        @(negedge clk);
        check_val("rmid_busy", 64'(busy_a), 64'd0);
        check_val("rmid_ack", 64'(bus_a.ack), 64'd0);
        check_val("rmid_mem_en", 64'(bus_a.mem_en), 64'd0);
        reset = 1'b0;
        set_port(1'b0, 0, 1'b1, 1'b0, 32'h50, 32'h0);
        h = cyc;
        expect_access(1'b0, h, 0, 1'b0, 32'h50, 32'h0, 1'b1);
        expect_access(1'b0, h + 4, 1, 1'b0, 32'h300, 32'h0, 1'b1);
        wait_until(h + 3);
        set_port(1'b0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_until(h + 7);
        set_port(1'b0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // LAT=3: read then write
        set_port(1'b1, 0, 1'b1, 1'b0, 32'h200, 32'h0);
        g = cyc;
        expect_access(1'b1, g, 0, 1'b0, 32'h200, 32'h0, 1'b1);
        wait_until(g + 5);
        check_val("l3_busy_c5", 64'(busy_b), 64'd1);
        set_port(1'b1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_val("l3_busy_c6", 64'(busy_b), 64'd0);
        set_port(1'b1, 2, 1'b1, 1'b1, 32'h4000, 32'h0BAD_CAFE);
        g = cyc;
        expect_access(1'b1, g, 2, 1'b1, 32'h4000, 32'h0BAD_CAFE, 1'b1);
        wait_until(g + 5);
        set_port(1'b1, 2, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(negedge clk);

        check_val("a.mem_left", 64'(mq_a.size()), 64'd0);
        check_val("a.ack_left", 64'(aq_a.size()), 64'd0);
        check_val("b.mem_left", 64'(mq_b.size()), 64'd0);
        check_val("b.ack_left", 64'(aq_b.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous memory among N requesters (instruction fetch, data port, loader/debug) in the tenyr SoC. The block sits between the core's `i_addr`/`d_addr` buses and the block RAM. It arbitrates round-robin and sequences each access through a fixed-latency memory handshake. Each requester sees a req/ack protocol: hold the request, get a one-cycle ack with read data.

## Interface
- `N`, 3: number of requesters; port 0 has first priority after reset.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `LAT`, 1: memory read latency in cycles, ≥1.
- `clk` in 1: sole clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in N: per-port request, held until that port's ack.
- `rw` in N: per-port direction, 1 = write.
- `addr` in N*AW: port i at `[i*AW +: AW]`.
- `wdata` in N*DW: port i at `[i*DW +: DW]`.
- `ack` out N: one-cycle completion pulse, at most one bit set.
- `rdata` out DW: read data, valid only while `ack` is nonzero.
- `busy` out 1: high whenever state ≠ IDLE.
- `mem_en` out 1: memory access strobe.
- `mem_rw` out 1: memory direction, 1 = write.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data, valid LAT cycles after the `mem_en` cycle.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, ACK.
- **IDLE:** if any `req` is set, select the winner g, capture `rw[g]`, `addr[g]` and `wdata[g]`, then go to ISSUE. Otherwise stay in IDLE.
- **ISSUE:** `mem_en`=1, and `mem_rw`/`mem_addr`/`mem_wdata` come from the captured values. Then go to WAIT with counter = LAT.
- **WAIT:** decrement the counter each cycle. On the cycle the counter reaches 1 (the cycle `mem_rdata` is valid), capture `mem_rdata` (reads) or 0 (writes), then go to ACK.
- **ACK:** `ack[g]`=1 and `rdata` = captured value. Then go to IDLE.
- **Round-robin:** the pointer `last` holds the previous winner. The search order is last+1, last+2, … mod N. `last` updates on every grant. Reset value is N-1, so port 0 wins first.
- **Memory outputs:** all are registered. `mem_addr`/`mem_wdata`/`mem_rw` are 0 outside ISSUE, and `mem_en` is 0 outside ISSUE.
- **`rdata`:** registered, and 0 outside ACK.
- **Request changes during service:** a `req`, `addr` or `wdata` change after capture does not affect the access in flight. The ack still pulses to the granted port. Dropping `req` before ack is a protocol violation, but is tolerated.
- **Requests during ACK:** a `req` asserted during ACK is not considered until the following IDLE cycle. A port whose `req` stays high after its ack is treated as a new request in that IDLE cycle.
- **Address and data width:** addresses and data pass through unmodified, with no arithmetic. The WAIT counter is `$clog2(LAT+1)` bits wide.

## Timing
- **Reset values:** `ack`=0, `rdata`=0, `busy`=0, `mem_en`=0, `mem_rw`=0, `mem_addr`=0, `mem_wdata`=0, state=IDLE, `last`=N-1.
- **Read or write, `req` seen in cycle c (IDLE):**
  - `mem_en` high in c+1;
  - `mem_rdata` sampled in c+1+LAT;
  - `ack` in c+2+LAT;
  - IDLE again in c+3+LAT.
- **Per-access cost:** 3+LAT cycles, i.e. 4 cycles at LAT=1. There is no pipelining and no back-to-back overlap.
- **Reset mid-operation:** `reset` high in any state gives IDLE and all outputs at their reset values on the next cycle. The outstanding access is discarded and its ack never pulses. A write already strobed in ISSUE is not undone.
- **Simultaneous `reset` and `req`:** reset wins.

## Structure
- State encodings (2-bit, IDLE=0, ISSUE=1, WAIT=2, ACK=3) and the LAT default go in `common.vh` as `` `define``s alongside the existing core constants.
- Sub-module `rr_pick` is combinational. Inputs: `req[N]`, `last`. Outputs: `any`, `winner` (`$clog2(N)` bits).
- The FSM, capture registers and counter live in `mem_arbiter`.
- Target size is 150–250 lines of RTL.

## Test plan
- **Single read:** LAT=1, after reset, `req[1]` with addr 0x100 in cycle 0; memory model returns 0xDEADBEEF.
  - `mem_en`=1, `mem_addr`=0x100, `mem_rw`=0 in cycle 1.
  - `ack`=3'b010, `rdata`=0xDEADBEEF in cycle 3.
  - `busy` low from cycle 4.
- **Write:** `req[2]` with `rw`=1, addr 0x1000, wdata 0x12345678.
  - `mem_rw`=1 and `mem_wdata`=0x12345678 in the ISSUE cycle only.
  - `ack`=3'b100 with `rdata`=0, three cycles later.
- **Fairness:** all three `req` held high continuously from reset.
  - Ack order 0,1,2,0,1,2, one ack every 4 cycles.
  - Never two `ack` bits set at once.
- **Skip idle port:** ports 0 and 2 requesting continuously, port 1 idle.
  - Grants alternate 0,2,0,2.
  - `mem_addr` matches each port's address.
- **Reset mid-access:** `reset` asserted in the WAIT cycle of a port-1 read.
  - Next cycle: IDLE, `ack`=0, `mem_en`=0.
  - Post-reset simultaneous `req[1]`,`req[0]` grants port 0 first.
- **Longer latency:** LAT=3, single read `req` in cycle 0.
  - `mem_en` in cycle 1, `mem_rdata` sampled in cycle 4.
  - `ack` in cycle 5, IDLE in cycle 6.
